hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks pending lw and mul/div destination registers with
// per-register down-counters and generates the FD stall, its reason, and a
// saturating count of stalled cycles.
module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      fd_insn,
  input  logic             fd_valid,
  input  logic             flush,
  input  logic             md_done,
  output logic             stall,
  output logic [1:0]       stall_reason,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW      = ($clog2(MAX_LAT + 1) < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    R_NONE      = 2'b00,
    R_LOAD_USE  = 2'b01,
    R_MD_RAW    = 2'b10,
    R_MD_STRUCT = 2'b11
  } reason_e;

  logic [4:0] opcode, rd, rs1, rs2, alu_op;
  logic [4:0] src_a, src_b;
  logic       use_a, use_b, writes_rd;
  logic       is_lw, is_md;

  logic [CW-1:0] cnt [NREGS];
  logic [4:0]    md_rd;
  logic          md_valid;
  logic          md_busy;

  logic    haz_a, haz_b, md_a, md_b;
  logic    load_use, md_raw, md_struct;
  reason_e reason;
  logic    issue, load_en, md_kill;
  logic [CW-1:0] load_val;

  assign opcode = fd_insn[31:27];
  assign rd     = fd_insn[26:22];
  assign rs1    = fd_insn[21:17];
  assign rs2    = fd_insn[16:12];
  assign alu_op = fd_insn[6:2];

  assign is_lw = (opcode == OP_LW);
  assign is_md = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

  // Decode which register fields the FD instruction reads and whether it writes rd.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    use_a     = 1'b0;
    use_b     = 1'b0;
    src_a     = rs1;
    src_b     = rs2;
    writes_rd = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_a     = 1'b1;
        use_b     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_a     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_SW, OP_BNE, OP_BLT: begin
        use_a = 1'b1;
        use_b = 1'b1;
        src_b = rd;
      end
      OP_JR: begin
        use_a = 1'b1;
        src_a = rd;
      end
      default: ;
    endcase
  end

  // Busy bits mirror non-zero counters; register 0 is never busy.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREGS; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign md_busy = md_valid && busy_vec[md_rd];

  // Classify the hazard; load-use outranks mul/div RAW, which outranks structural/WAW.
  always_comb begin
    haz_a     = use_a && (src_a != 5'd0) && busy_vec[src_a];
    haz_b     = use_b && (src_b != 5'd0) && busy_vec[src_b];
    md_a      = haz_a && md_busy && (src_a == md_rd);
    md_b      = haz_b && md_busy && (src_b == md_rd);
    load_use  = (haz_a && !md_a) || (haz_b && !md_b);
    md_raw    = md_a || md_b;
    md_struct = (is_md && md_busy) || (writes_rd && (rd != 5'd0) && busy_vec[rd]);
    stall     = fd_valid && !flush && (load_use || md_raw || md_struct);
    reason    = R_NONE;
    if (stall) begin
      if (load_use)    reason = R_LOAD_USE;
      else if (md_raw) reason = R_MD_RAW;
      else             reason = R_MD_STRUCT;
    end
  end

  assign stall_reason = reason;

  assign issue    = fd_valid && !flush && !stall;
  assign load_en  = issue && (is_lw || is_md) && (rd != 5'd0);
  assign load_val = is_lw ? CW'(LOAD_LAT) : CW'(MD_LAT);
  assign md_kill  = md_done && md_busy;

  // Per-register countdown: a new load wins over md_done, otherwise count toward zero.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: the counter array is reset like any other flops because busy_vec and
    // stall are decoded straight from it; it must never hold stale pending state.
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every counter update based on pre-edge values.
      for (int i = 1; i < NREGS; i++) begin
        if (load_en && (rd == 5'(i)))           cnt[i] <= load_val;
        else if (md_kill && (md_rd == 5'(i)))   cnt[i] <= '0;
        else if (cnt[i] != '0)                  cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Remember the destination of the single outstanding mul/div.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_rd    <= '0;
      md_valid <= 1'b0;
    end else if (load_en && is_md) begin
      md_rd    <= rd;
      md_valid <= 1'b1;
    end else if (md_kill || !busy_vec[md_rd]) begin
      md_valid <= 1'b0;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           stall_count <= '0;
    else if (stall && (stall_count != '1))  stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance for the functional
// scenarios and a CNT_W=4 instance for counter saturation and async reset.
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset_n, rst2_n;
  logic [31:0] fd_insn, fd_insn2;
  logic        fd_valid, fd_valid2;
  logic        flush, md_done;
  logic        stall, stall2;
  logic [1:0]  stall_reason, stall_reason2;
  logic [31:0] busy_vec, busy_vec2;
  logic [15:0] stall_count;
  logic [3:0]  stall_count2;
  logic        flush2, md_done2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  hazard_scoreboard u_dut (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .fd_valid(fd_valid),
    .flush(flush), .md_done(md_done), .stall(stall), .stall_reason(stall_reason),
    .busy_vec(busy_vec), .stall_count(stall_count)
  );

  hazard_scoreboard #(.CNT_W(4)) u_sat (
    .clock(clock), .reset_n(rst2_n), .fd_insn(fd_insn2), .fd_valid(fd_valid2),
    .flush(flush2), .md_done(md_done2), .stall(stall2), .stall_reason(stall_reason2),
    .busy_vec(busy_vec2), .stall_count(stall_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs1, rs2, alu);
    return {5'b00000, rd, rs1, rs2, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs1);
    return {op, rd, rs1, 17'h0};
  endfunction

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rst2_n = 1'b0;
    fd_insn = '0; fd_valid = 1'b0; flush = 1'b0; md_done = 1'b0;
    fd_insn2 = '0; fd_valid2 = 1'b0; flush2 = 1'b0; md_done2 = 1'b0;
    #1;
    check("reset_stall", stall, 0);
    check("reset_reason", stall_reason, 0);
    check("reset_busy", busy_vec, 0);
    check("reset_count", stall_count, 0);
    tick(); tick();
    reset_n = 1'b1; rst2_n = 1'b1;
    tick();

    // Load-use: lw r5 then add r6,r5,r1 stalls exactly one cycle.
    fd_insn = itype(OP_LW, 5'd5, 5'd1); fd_valid = 1'b1;
    #1 check("lw_issue_nostall", stall, 0);
    tick();
    fd_insn = rtype(5'd6, 5'd5, 5'd1, ALU_ADD);
    #1;
    check("lu_stall", stall, 1);
    check("lu_reason", stall_reason, 2'b01);
    check("lu_busy", busy_vec, 32'h0000_0020);
    tick();
    check("lu_release", stall, 0);
    check("lu_busy_clear", busy_vec, 0);
    check("lu_count", stall_count, 1);
    tick();

    // sw reads rd as a source; lw r0 is never tracked.
    fd_insn = itype(OP_LW, 5'd5, 5'd1);
    tick();
    fd_insn = itype(OP_SW, 5'd5, 5'd2);
    #1;
    check("sw_rd_stall", stall, 1);
    check("sw_rd_reason", stall_reason, 2'b01);
    tick();
    check("sw_release", stall, 0);
    fd_insn = itype(OP_LW, 5'd0, 5'd1);
    tick();
    fd_insn = itype(OP_SW, 5'd0, 5'd2);
    #1;
    check("lw_r0_nostall", stall, 0);
    check("lw_r0_busy", busy_vec, 0);
    tick();

    // mul r7, dependent add stalls 4 cycles until md_done is sampled.
    fd_insn = rtype(5'd7, 5'd1, 5'd2, ALU_MUL);
    tick();
    fd_insn = rtype(5'd8, 5'd7, 5'd7, ALU_ADD);
    #1;
    check("md_busy7", busy_vec, 32'h0000_0080);
    check("md_raw_c1", stall_reason, 2'b10);
    tick();
    check("md_raw_c2", stall, 1);
    tick();
    check("md_raw_c3", stall, 1);
    tick();
    md_done = 1'b1;
    #1 check("md_raw_c4", stall_reason, 2'b10);
    tick();
    md_done = 1'b0;
    check("md_release", stall, 0);
    check("md_busy_clear", busy_vec, 0);
    check("md_count", stall_count, 6);
    tick();

    // md_done with nothing outstanding must not clear a fresh load.
    fd_insn = itype(OP_LW, 5'd3, 5'd1); md_done = 1'b1;
    tick();
    check("stray_md_done", busy_vec, 32'h0000_0008);
    md_done = 1'b0; fd_valid = 1'b0;
    tick();
    check("lw3_expired", busy_vec, 0);

    // Structural: div while mul outstanding waits for md_done, then issues.
    fd_valid = 1'b1;
    fd_insn = rtype(5'd7, 5'd1, 5'd2, ALU_MUL);
    tick();
    fd_insn = rtype(5'd9, 5'd1, 5'd2, ALU_DIV);
    #1;
    check("struct_stall", stall, 1);
    check("struct_reason", stall_reason, 2'b11);
    tick();
    check("struct_reason2", stall_reason, 2'b11);
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    check("struct_release", stall, 0);
    tick();
    check("div_busy9", busy_vec, 32'h0000_0200);
    fd_valid = 1'b0; md_done = 1'b1;
    tick();
    md_done = 1'b0;
    check("div_done", busy_vec, 0);

    // Priority: load-use over mul/div RAW when both sources are pending.
    fd_valid = 1'b1;
    fd_insn = rtype(5'd7, 5'd1, 5'd2, ALU_MUL);
    tick();
    fd_insn = itype(OP_LW, 5'd5, 5'd1);
    #1 check("lw_behind_mul", stall, 0);
    tick();
    fd_insn = rtype(5'd8, 5'd5, 5'd7, ALU_ADD);
    #1 check("prio_load", stall_reason, 2'b01);
    tick();
    check("prio_md", stall_reason, 2'b10);
    md_done = 1'b1;
    tick();
    md_done = 1'b0; fd_valid = 1'b0;
    check("prio_release", stall, 0);

    // WAW on the mul destination, then flush suppresses stall and issue.
    fd_valid = 1'b1;
    fd_insn = rtype(5'd7, 5'd1, 5'd2, ALU_MUL);
    tick();
    fd_insn = itype(OP_ADDI, 5'd7, 5'd1);
    #1 check("waw_reason", stall_reason, 2'b11);
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    check("flush_reason", stall_reason, 0);
    tick();
    flush = 1'b0; fd_valid = 1'b0; md_done = 1'b1;
    tick();
    md_done = 1'b0;
    check("waw_cleared", busy_vec, 0);
    fd_valid = 1'b1; flush = 1'b1;
    fd_insn = itype(OP_LW, 5'd6, 5'd1);
    tick();
    flush = 1'b0; fd_valid = 1'b0;
    check("flushed_lw", busy_vec, 0);
    check("final_count", stall_count, 10);

    // Saturation with CNT_W=4, then asynchronous reset mid-stall.
    fd_valid2 = 1'b1;
    fd_insn2 = rtype(5'd7, 5'd1, 5'd2, ALU_MUL);
    tick();
    fd_insn2 = rtype(5'd8, 5'd7, 5'd7, ALU_ADD);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", stall2, 1);
    check("sat_count", stall_count2, 4'hF);
    #2 rst2_n = 1'b0;
    #1;
    check("arst_stall", stall2, 0);
    check("arst_reason", stall_reason2, 0);
    check("arst_busy", busy_vec2, 0);
    check("arst_count", stall_count2, 0);
    tick();
    rst2_n = 1'b1;
    #1 check("post_reset_empty", stall2, 0);
    tick();
    check("post_reset_busy", busy_vec2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
